// File: rtl/dem_switch_tree.sv
// dem_switch_tree
//   Pipelined dynamic-element-matching encoder. A quantizer count is split
//   down a binary tree of switching nodes, one register stage per layer, into
//   a 2^WIDTH-bit unit-element enable vector for a unary DAC. A 16-bit
//   Fibonacci LFSR supplies the pseudorandom switching bits. Supported modes
//   are thermometer, random and first-order noise-shaped.
//
// Ports
//   clk_i    : clock
//   reset_i  : asynchronous active-high reset
//   valid_i  : input sample valid
//   x_in_i   : quantizer count, legal 0..2^WIDTH (larger values are clamped)
//   mode_i   : 00 thermometer, 01 random, 10 noise-shaped, 11 random
//   valid_o  : output sample valid, WIDTH cycles after valid_i
//   elem_o   : unit-element enables, one bit per element
//   ovr_o    : this sample was out of range and was clamped
//   sum_o    : number of enabled elements (equals the clamped count)
module dem_switch_tree #(
  parameter int          WIDTH     = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               valid_i,
  input  logic [WIDTH:0]     x_in_i,
  input  logic [1:0]         mode_i,
  output logic               valid_o,
  output logic [2**WIDTH-1:0] elem_o,
  output logic               ovr_o,
  output logic [WIDTH:0]     sum_o
);

  localparam int NE = 2**WIDTH;   // unit elements
  localparam int NN = NE - 1;     // switching nodes
  localparam logic [WIDTH:0] XMAX = {1'b1, {WIDTH{1'b0}}};

  // Input clamp
  logic           w_ovr_in;
  logic [WIDTH:0] w_xc;

  assign w_ovr_in = (x_in_i > XMAX);
  assign w_xc     = w_ovr_in ? XMAX : x_in_i;

  // PN source: x^16+x^14+x^13+x^11+1, steps once per valid input sample.
  logic [15:0]   r_lfsr;
  logic          w_fb;
  logic [NN-1:0] w_pn0;

  assign w_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_lfsr <= LFSR_SEED;
    end else if (valid_i) begin
      r_lfsr <= {w_fb, r_lfsr[15:1]};
    end
  end

  // Node j (breadth-first) takes bit j mod 16 of the LFSR state seen by its
  // sample. The per-node bits are captured at entry and carried down the
  // pipeline; each layer strips off the bits it consumes.
  for (genvar j = 0; j < NN; j++) begin : g_pn
    assign w_pn0[j] = r_lfsr[j % 16];
  end

  // Tree layers. Layer n has 2^n nodes whose inputs are at most 2^(WIDTH-n)
  // and whose outputs are at most 2^(WIDTH-n-1). Child 2i is the lower and
  // child 2i+1 the upper output of node i, so leaf position equals element
  // index with upper children on higher indices.
  for (genvar n = 0; n < WIDTH; n++) begin : g_layer
    localparam int NI = 2**n;              // nodes in this layer
    localparam int IW = WIDTH - n + 1;     // input value width
    localparam int OW = WIDTH - n;         // output value width
    localparam int PW = NE - NI;           // pn bits entering this layer
    localparam int RW = PW - NI;           // pn bits passed to the next layer
    localparam logic [IW-1:0] HALF_I = IW'(2**(WIDTH-n-1));
    localparam logic [OW-1:0] HALF_O = OW'(2**(WIDTH-n-1));

    logic                   w_v;
    logic                   w_ovr;
    logic [1:0]             w_m;
    logic [WIDTH:0]         w_sum;
    logic [NI-1:0][IW-1:0]  w_xin;
    logic [PW-1:0]          w_pn;

    logic [2*NI-1:0][OW-1:0] w_val;
    logic [NI-1:0]           w_ns;

    logic                    r_vld;
    logic                    r_ovr;
    logic [WIDTH:0]          r_sum;
    logic [2*NI-1:0][OW-1:0] r_val;
    logic [NI-1:0]           r_ns;   // noise-shaping node states

    if (n == 0) begin : g_src
      assign w_v   = valid_i;
      assign w_ovr = w_ovr_in;
      assign w_m   = mode_i;
      assign w_sum = w_xc;
      assign w_xin = w_xc;
      assign w_pn  = w_pn0;
    end else begin : g_src
      assign w_v   = g_layer[n-1].r_vld;
      assign w_ovr = g_layer[n-1].r_ovr;
      assign w_m   = g_layer[n-1].g_fwd.r_mode;
      assign w_sum = g_layer[n-1].r_sum;
      assign w_xin = g_layer[n-1].r_val;
      assign w_pn  = g_layer[n-1].g_fwd.r_pn;
    end

    for (genvar i = 0; i < NI; i++) begin : g_node
      logic [IW-1:0] w_x;
      logic [OW-1:0] w_up;
      logic [OW-1:0] w_lo;
      logic          w_odd;
      logic          w_plus;

      assign w_x    = w_xin[i];
      assign w_odd  = w_x[0];
      assign w_plus = (w_m == 2'b10) ? ~r_ns[i] : w_pn[i];

      // Thermometer fills the upper child to capacity first, giving a
      // contiguous run of MSBs. The other modes split evenly and put the odd
      // unit on the side chosen by s: upper = floor(x/2) + (odd & s=+1).
      always_comb begin
        w_up = '0;
        if (w_m == 2'b00) begin
          w_up = (w_x > HALF_I) ? HALF_O : w_x[OW-1:0];
        end else begin
          w_up = w_x[IW-1:1] + OW'(w_odd & w_plus);
        end
      end

      // Both children fit in OW bits, so the modular subtraction is exact.
      assign w_lo = w_x[OW-1:0] - w_up;

      assign w_val[2*i]   = w_lo;
      assign w_val[2*i+1] = w_up;
      assign w_ns[i]      = ((w_m == 2'b10) && w_odd) ? ~r_ns[i] : r_ns[i];
    end

    // Bubbles shift the valid bit but leave data and node state untouched.
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        r_vld <= 1'b0;
        r_ovr <= 1'b0;
        r_sum <= '0;
        r_val <= '0;
        r_ns  <= '0;
      end else begin
        r_vld <= w_v;
        if (w_v) begin
          r_ovr <= w_ovr;
          r_sum <= w_sum;
          r_val <= w_val;
          r_ns  <= w_ns;
        end
      end
    end

    if (n < WIDTH-1) begin : g_fwd
      logic [1:0]    r_mode;
      logic [RW-1:0] r_pn;

      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          r_mode <= '0;
          r_pn   <= '0;
        end else if (w_v) begin
          r_mode <= w_m;
          r_pn   <= w_pn[PW-1:NI];
        end
      end
    end
  end

  assign valid_o = g_layer[WIDTH-1].r_vld;
  assign elem_o  = g_layer[WIDTH-1].r_val;
  assign ovr_o   = g_layer[WIDTH-1].r_ovr;
  assign sum_o   = g_layer[WIDTH-1].r_sum;

endmodule
